enc_key_input: RTL and testbench
================================

# enc_key_input

Input-conditioning stage that sits directly upstream of the seven-segment display driver. It turns raw board signals into the display's `enc` digit and `key` inputs. Those raw signals are the two quadrature lines of a detented rotary encoder and an active-low push button. Each raw input is synchronised and debounced, and the encoder's Gray sequence is decoded into a 4-bit hex value that steps once per detent. The block also produces a clean key level and a one-cycle press pulse.

## Interface
- `DEB_CYCLES`, default 16: consecutive stable cycles required before a debounced signal changes. Legal range is 1..65535.
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-low
- `qa`  in  1  encoder channel A, asynchronous, raw
- `qb`  in  1  encoder channel B, asynchronous, raw
- `key_n`  in  1  push button, asynchronous, raw, active-low
- `enc`  out  4  current digit value, feeds the display `enc` input
- `key`  out  1  debounced button level, 1 = pressed, feeds the display `key` input
- `key_pulse`  out  1  one-cycle pulse on each press edge
- `step_err`  out  1  one-cycle pulse on an illegal encoder transition

## Operation
- Synchronisers:
  - Each raw input passes through a 2-flop synchroniser.
  - `key_n` is inverted after synchronisation.
- Debounce, per signal:
  - A counter restarts whenever the synchronised input differs from the current debounced value.
  - When the input has held the differing level for `DEB_CYCLES` consecutive cycles, the debounced value takes the new level and the counter clears.
  - A glitch shorter than `DEB_CYCLES` cycles never reaches the debounced output.
- Quadrature decode, on debounced AB = {A,B}, evaluated each cycle against the previous debounced AB:
  - The clockwise (CW) sequence is 00→01→11→10→00. Each CW transition adds +1 to a signed 3-bit quarter count `q`.
  - Each transition of the reverse sequence (counter-clockwise, CCW) adds −1 to `q`.
  - When AB enters 00:
    - `q` == +4 → `enc` increments.
    - `q` == −4 → `enc` decrements.
    - In all cases `q` is then cleared to 0.
  - Partial rotations that return to 00 (for example 00→01→00) produce no step.
  - Illegal transition, meaning both bits change at once: `q` is cleared, `enc` is unchanged, and `step_err` pulses. If AB lands on 00 this way, no step occurs.
- `enc` arithmetic is modulo 16: F+1 = 0 and 0−1 = F.
- Key:
  - `key` is the debounced level.
  - `key_pulse` = `key` & ~`key_d`, where `key_d` is `key` delayed by one cycle.
  - Releasing the button produces no pulse.
  - Encoder and key paths are independent. A press occurring in the same cycle as an `enc` step does not affect that step.

## Timing
- Reset: with `rst` = 0 sampled on a rising edge:
  - `enc` = 0, `key` = 0, `key_pulse` = 0, `step_err` = 0.
  - `q` = 0.
  - All debounce counters are 0.
  - Synchroniser flops take their idle values: A = 0, B = 0, `key_n` = 1.
  - Debounced AB = 00.
- Reset mid-rotation discards the partial `q`. After reset, the encoder must return to AB = 00 before any step can be counted.
- Latency from a raw edge (held stable) to its debounced change: 2 synchroniser cycles + `DEB_CYCLES` cycles.
- `enc` and `key` update in the cycle after the debounced change. `key_pulse` and `step_err` are high in that same cycle, for exactly one cycle.
- Worst-case latency from a raw edge to `enc` or `key`: `DEB_CYCLES` + 3 cycles.
- Maximum countable rate: one quarter-transition per `DEB_CYCLES` + 1 cycles. Faster input is filtered and may produce `step_err`.
- The simultaneous A and B debounced changes that cause `step_err` are resolved in one cycle.

## Configuration
- `ENC_SATURATE_EN` defined: `enc` saturates. An increment at F holds F, and a decrement at 0 holds 0. The saturated step is silently dropped, with no `step_err`.
- `ENC_SATURATE_EN` undefined: `enc` wraps modulo 16, which is the default.

## Structure
- Package `enc_key_pkg` holds:
  - Gray state constants `AB_00`, `AB_01`, `AB_11`, `AB_10`.
  - Quarter-step constants `Q_CW` = +1 and `Q_CCW` = −1.
  - The detent threshold `Q_DETENT` = 4.
  - The `enc` width constant `ENC_W` = 4.
- Sub-module `deb_filter`, parameterised by `DEB_CYCLES`, contains the synchroniser and debounce. It is instantiated 3× (A, B, `key_n`).
- The top level contains the quadrature decoder, `q` accumulator, `enc` register and key edge detect.

## Test plan
- Reset and idle: assert `rst` = 0 for 3 cycles, with `qa` = `qb` = 0 and `key_n` = 1. Expect `enc` = 0, `key` = 0 and no pulses for 200 cycles after release.
- CW detents: `DEB_CYCLES` = 4. Drive 5 full CW sequences, holding each state for 10 cycles. Expect `enc` 0→5, each step at the AB-enters-00 point, with `step_err` = 0.
- CCW wrap: from `enc` = 0, drive 2 CCW detents. Expect F, then E. With `ENC_SATURATE_EN` defined, expect 0, then 0.
- Bounce rejection:
  - Toggle `key_n` with 2-cycle glitches for 30 cycles, then hold it at 0. Expect exactly one `key_pulse`, `DEB_CYCLES` + 3 cycles after the hold starts, and `key` = 1.
  - Release the button. Expect no pulse.
- Illegal and partial transitions:
  - Drive AB 00→11. Expect one `step_err` pulse and `enc` unchanged.
  - Drive 00→01→00. Expect no step.
- Reset mid-detent: after 3 CW quarters, pulse `rst` low for 1 cycle, then finish the sequence. Expect `enc` = 0 and no increment.

Source files
------------

// File: rtl/enc_key_pkg.sv
// enc_key_pkg: shared constants and helpers for the encoder/key input stage.
//   AB_xx     Gray states of the debounced quadrature pair {A,B}
//   Q_CW/CCW  quarter-step increments for the 3-bit two's-complement quarter count
//   Q_DETENT  quarter count that marks one full detent
//   ENC_W     width of the digit value
//   classify  sorts a {prev,cur} AB pair into hold / CW / CCW / illegal
package enc_key_pkg;

    localparam int unsigned ENC_W = 4;

    localparam logic [1:0] AB_00 = 2'b00;
    localparam logic [1:0] AB_01 = 2'b01;
    localparam logic [1:0] AB_11 = 2'b11;
    localparam logic [1:0] AB_10 = 2'b10;

    localparam logic [2:0] Q_CW  = 3'b001;  // +1
    localparam logic [2:0] Q_CCW = 3'b111;  // -1

    localparam int Q_DETENT = 4;

    typedef enum logic [1:0] {
        TrHold,
        TrCw,
        TrCcw,
        TrIllegal
    } trans_e;

    // Successor of a state in the clockwise sequence 00->01->11->10->00.
    function automatic logic [1:0] cw_next(input logic [1:0] ab);
        logic [1:0] nxt;
        unique case (ab)
            AB_00: nxt = AB_01;
            AB_01: nxt = AB_11;
            AB_11: nxt = AB_10;
            AB_10: nxt = AB_00;
        endcase
        return nxt;
    endfunction

    function automatic trans_e classify(input logic [1:0] prev, input logic [1:0] cur);
        trans_e tr;
        if (cur == prev) begin
            tr = TrHold;
        end else if (cur == cw_next(prev)) begin
            tr = TrCw;
        end else if (prev == cw_next(cur)) begin
            tr = TrCcw;
        end else begin
            tr = TrIllegal;  // both bits flipped together
        end
        return tr;
    endfunction

endpackage

// File: rtl/deb_filter.sv
// deb_filter: 2-flop synchroniser followed by a stable-count debouncer.
//   DEB_CYCLES  consecutive stable cycles needed before the output follows (1..65535)
//   RESET_VAL   idle level loaded into the synchroniser and output on reset
//   clk         system clock
//   rst         synchronous active-low reset
//   raw_i       asynchronous raw input
//   deb_o       synchronised, debounced level
module deb_filter #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter bit          RESET_VAL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic deb_o
);

    localparam logic [15:0] CntMax = 16'(DEB_CYCLES - 1);

    logic        sync1_q, sync2_q;
    logic        deb_q, deb_d;
    logic [15:0] cnt_q, cnt_d;

    // Counter runs only while the synchronised input disagrees with the output;
    // any return to agreement restarts it, so short glitches never get through.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CntMax) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
            deb_q   <= RESET_VAL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/enc_key_input.sv
// enc_key_input: conditions a detented quadrature encoder and an active-low
// push button into a 4-bit digit and a clean key level/pulse.
//   DEB_CYCLES  debounce stable-cycle count (1..65535)
//   clk         system clock
//   rst         synchronous active-low reset
//   qa, qb      raw encoder channels A and B
//   key_n       raw push button, active-low
//   enc         digit value, steps once per detent
//   key         debounced button level, 1 = pressed
//   key_pulse   one-cycle pulse on each press
//   step_err    one-cycle pulse on an illegal (double-bit) encoder transition
// Build option: define ENC_SATURATE_EN to make enc saturate at 0 and F
// instead of wrapping modulo 16.
module enc_key_input
    import enc_key_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             qa,
    input  logic             qb,
    input  logic             key_n,
    output logic [ENC_W-1:0] enc,
    output logic             key,
    output logic             key_pulse,
    output logic             step_err
);

    localparam logic [3:0] QDetPos = 4'(Q_DETENT);
    localparam logic [3:0] QDetNeg = 4'(-Q_DETENT);

    logic deb_a, deb_b, deb_key_n;

    deb_filter #(.DEB_CYCLES(DEB_CYCLES), .RESET_VAL(1'b0)) u_deb_a (
        .clk   (clk),
        .rst   (rst),
        .raw_i (qa),
        .deb_o (deb_a)
    );

    deb_filter #(.DEB_CYCLES(DEB_CYCLES), .RESET_VAL(1'b0)) u_deb_b (
        .clk   (clk),
        .rst   (rst),
        .raw_i (qb),
        .deb_o (deb_b)
    );

    deb_filter #(.DEB_CYCLES(DEB_CYCLES), .RESET_VAL(1'b1)) u_deb_key (
        .clk   (clk),
        .rst   (rst),
        .raw_i (key_n),
        .deb_o (deb_key_n)
    );

    logic [1:0]       ab, ab_prev_q;
    logic [2:0]       q_q, q_d;
    logic [ENC_W-1:0] enc_q, enc_d;
    logic             step_err_d, step_err_q;
    logic             key_lvl, key_q, key_pulse_q;
    logic [3:0]       q_sum;
    trans_e           tr;

    assign ab      = {deb_a, deb_b};
    assign key_lvl = ~deb_key_n;
    assign tr      = classify(ab_prev_q, ab);

    always_comb begin
        q_d        = q_q;
        enc_d      = enc_q;
        step_err_d = 1'b0;
        // q_q never leaves -3..+3 while stored, but the 4th quarter reaches +/-4,
        // so the sum is formed one bit wider.
        q_sum      = {q_q[2], q_q};
        unique case (tr)
            TrHold: begin
            end
            TrCw: begin
                q_sum = {q_q[2], q_q} + {Q_CW[2], Q_CW};
            end
            TrCcw: begin
                q_sum = {q_q[2], q_q} + {Q_CCW[2], Q_CCW};
            end
            TrIllegal: begin
                step_err_d = 1'b1;
            end
        endcase

        if (tr == TrIllegal) begin
            q_d = '0;
        end else if (tr != TrHold) begin
            if (ab == AB_00) begin
                q_d = '0;
                if (q_sum == QDetPos) begin
`ifdef ENC_SATURATE_EN
                    if (enc_q != '1) enc_d = enc_q + 4'd1;
`else
                    enc_d = enc_q + 4'd1;
`endif
                end else if (q_sum == QDetNeg) begin
`ifdef ENC_SATURATE_EN
                    if (enc_q != '0) enc_d = enc_q - 4'd1;
`else
                    enc_d = enc_q - 4'd1;
`endif
                end
            end else begin
                q_d = q_sum[2:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ab_prev_q   <= AB_00;
            q_q         <= '0;
            enc_q       <= '0;
            step_err_q  <= 1'b0;
            key_q       <= 1'b0;
            key_pulse_q <= 1'b0;
        end else begin
            ab_prev_q   <= ab;
            q_q         <= q_d;
            enc_q       <= enc_d;
            step_err_q  <= step_err_d;
            key_q       <= key_lvl;
            key_pulse_q <= key_lvl & ~key_q;  // press edge only
        end
    end

    assign enc       = enc_q;
    assign key       = key_q;
    assign key_pulse = key_pulse_q;
    assign step_err  = step_err_q;

endmodule

// File: tb/tb_enc_key_input.sv
module tb_enc_key_input;

    logic       clk = 1'b0;
    logic       rst;
    logic       qa, qb, key_n;
    logic [3:0] enc;
    logic       key, key_pulse, step_err;

    int checks = 0;
    int errors = 0;
    int n_err  = 0;  // step_err pulses seen
    int n_kp   = 0;  // key_pulse pulses seen

    enc_key_input #(.DEB_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .qa        (qa),
        .qb        (qb),
        .key_n     (key_n),
        .enc       (enc),
        .key       (key),
        .key_pulse (key_pulse),
        .step_err  (step_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step_err) n_err++;
        if (key_pulse) n_kp++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ab(input logic [1:0] ab, input int n);
        {qa, qb} = ab;
        repeat (n) tick();
    endtask

    initial begin
        int         e0, k0, first;
        logic [3:0] exp_enc;
        logic [3:0] wrap1, wrap2;
`ifdef ENC_SATURATE_EN
        wrap1 = 4'h0;
        wrap2 = 4'h0;
`else
        wrap1 = 4'hF;
        wrap2 = 4'hE;
`endif

        // Reset and idle
        rst = 1'b0; qa = 1'b0; qb = 1'b0; key_n = 1'b1;
        repeat (3) tick();
        chk("rst_enc", enc, 0);
        chk("rst_key", key, 0);
        chk("rst_kp", key_pulse, 0);
        chk("rst_err", step_err, 0);
        rst = 1'b1;
        e0 = n_err; k0 = n_kp;
        repeat (200) tick();
        chk("idle_enc", enc, 0);
        chk("idle_key", key, 0);
        chk("idle_pulses", (n_err - e0) + (n_kp - k0), 0);

        // CW detents: first one with exact step timing (2 sync + 4 deb + 1)
        e0 = n_err;
        set_ab(2'b01, 10);
        set_ab(2'b11, 10);
        set_ab(2'b10, 10);
        chk("cw_partial_enc", enc, 0);
        set_ab(2'b00, 6);
        chk("cw_step_early", enc, 0);
        tick();
        chk("cw_step_time", enc, 1);
        repeat (3) tick();
        for (int i = 2; i <= 5; i++) begin
            set_ab(2'b01, 10);
            set_ab(2'b11, 10);
            set_ab(2'b10, 10);
            set_ab(2'b00, 10);
            chk("cw_enc", enc, i);
        end
        chk("cw_no_err", n_err - e0, 0);

        // CCW back to 0, then past it
        for (int i = 1; i <= 5; i++) begin
            set_ab(2'b10, 10);
            set_ab(2'b11, 10);
            set_ab(2'b01, 10);
            set_ab(2'b00, 10);
            chk("ccw_enc", enc, 5 - i);
        end
        set_ab(2'b10, 10); set_ab(2'b11, 10); set_ab(2'b01, 10); set_ab(2'b00, 10);
        chk("ccw_wrap1", enc, wrap1);
        set_ab(2'b10, 10); set_ab(2'b11, 10); set_ab(2'b01, 10); set_ab(2'b00, 10);
        chk("ccw_wrap2", enc, wrap2);
        chk("ccw_no_err", n_err - e0, 0);
        exp_enc = wrap2;

        // Key bounce: 2-cycle glitches never reach key
        k0 = n_kp;
        for (int i = 0; i < 30; i++) begin
            key_n = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
            tick();
        end
        chk("glitch_no_pulse", n_kp - k0, 0);
        chk("glitch_key", key, 0);
        key_n = 1'b0;
        first = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (key_pulse && first == 0) first = n;
        end
        chk("press_latency", first, 7);
        chk("press_count", n_kp - k0, 1);
        chk("press_key", key, 1);
        chk("press_enc", enc, exp_enc);
        k0 = n_kp;
        key_n = 1'b1;
        repeat (20) tick();
        chk("release_no_pulse", n_kp - k0, 0);
        chk("release_key", key, 0);

        // Illegal 00->11: single step_err, enc untouched
        e0 = n_err;
        set_ab(2'b11, 6);
        chk("illegal_early", step_err, 0);
        tick();
        chk("illegal_pulse", step_err, 1);
        tick();
        chk("illegal_one_cycle", step_err, 0);
        repeat (10) tick();
        chk("illegal_count", n_err - e0, 1);
        chk("illegal_enc", enc, exp_enc);
        set_ab(2'b10, 10);
        set_ab(2'b00, 10);
        chk("illegal_ret_enc", enc, exp_enc);

        // Partial 00->01->00
        e0 = n_err;
        set_ab(2'b01, 10);
        set_ab(2'b00, 10);
        chk("partial_enc", enc, exp_enc);
        chk("partial_no_err", n_err - e0, 0);

        // Reset mid-detent discards the partial quarter count
        set_ab(2'b01, 10);
        set_ab(2'b11, 10);
        set_ab(2'b10, 10);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst_enc", enc, 0);
        e0 = n_err;
        set_ab(2'b10, 10);
        set_ab(2'b00, 10);
        chk("midrst_no_step", enc, 0);
        chk("midrst_no_err", n_err - e0, 0);
        set_ab(2'b01, 10); set_ab(2'b11, 10); set_ab(2'b10, 10); set_ab(2'b00, 10);
        chk("post_rst_step", enc, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
